// File: rtl/vvtile_issuer.sv
// Instruction issue sequencer for the vvtile array: buffers host words in a
// small FIFO and broadcasts each one rep+1 times, with an optional idle gap.
module vvtile_issuer #(
    parameter int INSTR_WIDTH = 32,
    parameter int REP_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_CYCLES  = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [INSTR_WIDTH-1:0]         in_instr,
    input  logic [REP_WIDTH-1:0]           in_rep,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           flush,
    input  logic                           dbg_clk_enable,
    output logic [INSTR_WIDTH-1:0]         instruction,
    output logic                           inputValid,
    output logic                           busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifoCount,
    output logic [CNT_WIDTH-1:0]           issueCount
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t                          state;
    logic                            validFlag;
    logic [REP_WIDTH-1:0]            repCnt;
    logic [GW-1:0]                   gapCnt;

    logic [INSTR_WIDTH+REP_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]                   wrPtr, rdPtr;
    logic [AW:0]                     count;
    logic                            full, empty, push, pop;
    logic [INSTR_WIDTH-1:0]          headInstr;
    logic [REP_WIDTH-1:0]            headRep;

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full && !flush && !rst;
    assign push      = in_valid && in_ready;
    assign headInstr = mem[rdPtr][INSTR_WIDTH+REP_WIDTH-1:REP_WIDTH];
    assign headRep   = mem[rdPtr][REP_WIDTH-1:0];

    // Pop from IDLE, or back-to-back from ISSUE when no gap is configured.
    always_comb begin
        pop = 1'b0;
        if (!rst && !flush && dbg_clk_enable && !empty) begin
            case (state)
                IDLE:    pop = 1'b1;
                ISSUE:   pop = (repCnt == '0) && (GAP_CYCLES == 0);
                default: pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wrPtr] <= {in_instr, in_rep};
                wrPtr      <= wrPtr + AW'(1);
            end
            if (pop)
                rdPtr <= rdPtr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (!push && pop)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            validFlag   <= 1'b0;
            repCnt      <= '0;
            gapCnt      <= '0;
            instruction <= '0;
            issueCount  <= '0;
        end else if (flush) begin
            state     <= IDLE;
            validFlag <= 1'b0;
        end else if (dbg_clk_enable) begin
            if (validFlag)
                issueCount <= issueCount + CNT_WIDTH'(1);
            case (state)
                IDLE: begin
                    if (pop) begin
                        instruction <= headInstr;
                        repCnt      <= headRep;
                        validFlag   <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (repCnt != '0) begin
                        repCnt <= repCnt - REP_WIDTH'(1);
                    end else if (GAP_CYCLES > 0) begin
                        state     <= GAP;
                        validFlag <= 1'b0;
                        gapCnt    <= GW'(GAP_CYCLES - 1);
                    end else if (pop) begin
                        instruction <= headInstr;
                        repCnt      <= headRep;
                    end else begin
                        state     <= IDLE;
                        validFlag <= 1'b0;
                    end
                end
                GAP: begin
                    if (gapCnt == '0)
                        state <= IDLE;
                    else
                        gapCnt <= gapCnt - GW'(1);
                end
                default: begin
                    state     <= IDLE;
                    validFlag <= 1'b0;
                end
            endcase
        end
    end

    // A stalled cycle must never present an issue to the array.
    assign inputValid = validFlag && dbg_clk_enable;
    assign busy       = !empty || (state != IDLE);
    assign fifoCount  = count;
endmodule

// File: tb/tb_vvtile_issuer.sv
// Drives two issuers (no gap / 4-bit counter, and 2-cycle gap) with shared
// stimulus and compares every cycle against a queue-based reference model.
module tb_vvtile_issuer;
    localparam int IW = 32;
    localparam int RW = 8;
    localparam int D  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, inValid, flush, en;
    logic [IW-1:0] inInstr;
    logic [RW-1:0] inRep;

    logic          rdy0, iv0, busy0, rdy1, iv1, busy1;
    logic [IW-1:0] instr0, instr1;
    logic [2:0]    fc0, fc1;
    logic [3:0]    cnt0;
    logic [15:0]   cnt1;

    vvtile_issuer #(.GAP_CYCLES(0), .CNT_WIDTH(4)) dut0 (
        .clk(clk), .rst(rst), .in_instr(inInstr), .in_rep(inRep), .in_valid(inValid),
        .in_ready(rdy0), .flush(flush), .dbg_clk_enable(en), .instruction(instr0),
        .inputValid(iv0), .busy(busy0), .fifoCount(fc0), .issueCount(cnt0));

    vvtile_issuer #(.GAP_CYCLES(2), .CNT_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .in_instr(inInstr), .in_rep(inRep), .in_valid(inValid),
        .in_ready(rdy1), .flush(flush), .dbg_clk_enable(en), .instruction(instr1),
        .inputValid(iv1), .busy(busy1), .fifoCount(fc1), .issueCount(cnt1));

    int nCmp = 0;
    int nFail = 0;

    // Reference model: a word queue plus "issues left" and "idle cycles owed".
    typedef logic [IW+RW-1:0] ent_t;
    ent_t          q0[$], q1[$];
    int            mGap[2]    = '{0, 2};
    int            mMod[2]    = '{16, 65536};
    bit            mPres[2];
    int            mLeft[2], mGapLeft[2], mCnt[2];
    logic [IW-1:0] mInstr[2];

    function automatic int qSize(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qClear(int k);
        if (k == 0) q0.delete(); else q1.delete();
    endtask

    task automatic qPush(int k, ent_t e);
        if (k == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic startWord(int k);
        ent_t e;
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        mInstr[k] = e[IW+RW-1:RW];
        mLeft[k]  = int'(e[RW-1:0]) + 1;
        mPres[k]  = 1'b1;
    endtask

    task automatic modelReset(int k);
        qClear(k);
        mPres[k] = 1'b0; mLeft[k] = 0; mGapLeft[k] = 0; mCnt[k] = 0; mInstr[k] = '0;
    endtask

    task automatic modelEdge(int k);
        bit ready;
        ready = (qSize(k) < D) && !flush && !rst;
        if (rst) begin
            modelReset(k);
        end else if (flush) begin
            qClear(k);
            mPres[k] = 1'b0;
            mGapLeft[k] = 0;
        end else begin
            if (en) begin
                if (mPres[k]) begin
                    mCnt[k] = (mCnt[k] + 1) % mMod[k];
                    mLeft[k]--;
                    if (mLeft[k] == 0) begin
                        mPres[k] = 1'b0;
                        if (mGap[k] > 0) mGapLeft[k] = mGap[k];
                        else if (qSize(k) > 0) startWord(k);
                    end
                end else if (mGapLeft[k] > 0) begin
                    mGapLeft[k]--;
                end else if (qSize(k) > 0) begin
                    startWord(k);
                end
            end
            if (inValid && ready) qPush(k, {inInstr, inRep});
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOut();
        chk("iv0",    64'(iv0),    64'(mPres[0] && en));
        chk("instr0", 64'(instr0), 64'(mInstr[0]));
        chk("busy0",  64'(busy0),  64'(qSize(0) != 0 || mPres[0] || mGapLeft[0] > 0));
        chk("fc0",    64'(fc0),    64'(qSize(0)));
        chk("cnt0",   64'(cnt0),   64'(mCnt[0]));
        chk("iv1",    64'(iv1),    64'(mPres[1] && en));
        chk("instr1", 64'(instr1), 64'(mInstr[1]));
        chk("busy1",  64'(busy1),  64'(qSize(1) != 0 || mPres[1] || mGapLeft[1] > 0));
        chk("fc1",    64'(fc1),    64'(qSize(1)));
        chk("cnt1",   64'(cnt1),   64'(mCnt[1]));
    endtask

    // Inputs are already driven; check ready, advance the model, cross one edge.
    task automatic step(bit checkAfter = 1'b1);
        #1;
        if (checkAfter) begin
            chk("rdy0", 64'(rdy0), 64'(qSize(0) < D && !flush && !rst));
            chk("rdy1", 64'(rdy1), 64'(qSize(1) < D && !flush && !rst));
        end
        modelEdge(0);
        modelEdge(1);
        @(posedge clk);
        @(negedge clk);
        checkOut();
    endtask

    task automatic push(logic [IW-1:0] i, logic [RW-1:0] r);
        inValid = 1'b1; inInstr = i; inRep = r;
        step();
        inValid = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; inValid = 1'b0; flush = 1'b0; en = 1'b1; inInstr = '0; inRep = '0;
        modelReset(0);
        modelReset(1);
        @(negedge clk);
        step(1'b0);
        step();
        rst = 1'b0;

        // Single word, then two words without gap, then two rep=0 words
        push(32'hA5, 8'd0);
        idle(5);
        push(32'h11, 8'd2);
        push(32'h22, 8'd0);
        idle(8);
        push(32'h61, 8'd0);
        push(32'h62, 8'd0);
        idle(8);

        // Fill while stalled, one extra attempt while full, then release
        en = 1'b0;
        push(32'h41, 8'd1);
        push(32'h42, 8'd0);
        push(32'h43, 8'd2);
        push(32'h44, 8'd0);
        push(32'h45, 8'd0);
        idle(2);
        en = 1'b1;
        idle(24);

        // Flush after two issues of a long-repeat word with two words queued
        push(32'h33, 8'd5);
        push(32'h34, 8'd1);
        push(32'h35, 8'd0);
        for (int i = 0; i < 10 && !(mPres[0] && mLeft[0] == 4); i++) step();
        chk("flushReach", 64'(mPres[0] && mLeft[0] == 4), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flushInstr", 64'(instr0), 64'h33);
        chk("flushFc",    64'(fc0),    64'd0);
        idle(6);

        // Reset mid-issue, then a 17-issue word to wrap the 4-bit counter
        push(32'h55, 8'd3);
        idle(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstInstr", 64'(instr0), 64'd0);
        push(32'h77, 8'd16);
        idle(22);
        chk("wrapCnt0", 64'(cnt0), 64'd1);
        chk("cnt1_17",  64'(cnt1), 64'd17);

        // Randomized traffic with stalls, occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            inValid = 1'($urandom_range(0, 1));
            inInstr = $urandom;
            inRep   = RW'($urandom_range(0, 3));
            en      = ($urandom_range(0, 9) != 0);
            flush   = ($urandom_range(0, 49) == 0);
            rst     = ($urandom_range(0, 149) == 0);
            step();
        end
        inValid = 1'b0; flush = 1'b0; rst = 1'b0; en = 1'b1;
        idle(60);
        chk("drainBusy0", 64'(busy0), 64'd0);
        chk("drainBusy1", 64'(busy1), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule

// File: doc/vvtile_issuer.md
# vvtile_issuer

Instruction issue sequencer in front of the vvtile array. It accepts instruction words from the host over a valid/ready handshake and buffers them in a small FIFO. It drives the array's broadcast `instruction`/`inputValid` pair, repeating each instruction a programmable number of times. It inserts a fixed idle gap between distinct instructions so multi-stage inter-tile pipelines settle. It honours the same debug step-enable used by the tile array.

## Interface
- `INSTR_WIDTH`, 32: width of the tile-controller instruction word.
- `REP_WIDTH`, 8: width of the per-word repeat field.
- `FIFO_DEPTH`, 4: entries in the input FIFO; power of two, ≥2.
- `GAP_CYCLES`, 0: idle cycles (`inputValid`=0) inserted after each instruction's last issue.
- `CNT_WIDTH`, 16: width of the issue counter.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_instr`  in  INSTR_WIDTH  host instruction word.
- `in_rep`  in  REP_WIDTH  repeat count; word is issued `in_rep`+1 times.
- `in_valid`  in  1  host word valid.
- `in_ready`  out  1  FIFO can accept; transfer on `in_valid && in_ready`.
- `flush`  in  1  synchronous abort: empty FIFO, stop issuing.
- `dbg_clk_enable`  in  1  step enable; 0 freezes the issue side.
- `instruction`  out  INSTR_WIDTH  to array instruction port.
- `inputValid`  out  1  to array inputValid.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.
- `fifoCount`  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- `issueCount`  out  CNT_WIDTH  number of cycles with `inputValid`=1; wraps modulo 2^CNT_WIDTH.

## Operation
- Reset values:
  - FIFO empty; FSM in IDLE.
  - `instruction`=0, `inputValid`=0, `issueCount`=0, `busy`=0, `fifoCount`=0.
  - `in_ready`=0 while `rst`=1.
- Priority order: `rst` > `flush` > normal operation.
- FIFO:
  - `in_ready` = !full && !flush && !rst. It is low when full even if a pop occurs the same cycle.
  - Push and pop in the same cycle are allowed when not full. `fifoCount` is unchanged.
  - Pushes are accepted regardless of `dbg_clk_enable`.
- FSM states: IDLE, ISSUE, GAP. A state advances only on an edge where `dbg_clk_enable`=1 (an "enabled edge").
- IDLE:
  - If the FIFO is non-empty, pop: load `instruction` and the repeat counter with `in_rep`, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - The registered valid flag is 1.
  - On each enabled edge: if the repeat counter > 0, decrement it.
  - When the counter = 0 and GAP_CYCLES > 0: go to GAP and load the gap counter with GAP_CYCLES-1.
  - When the counter = 0, GAP_CYCLES = 0 and the FIFO is non-empty: pop the next word back-to-back and stay in ISSUE.
  - When the counter = 0, GAP_CYCLES = 0 and the FIFO is empty: go to IDLE.
- GAP:
  - The valid flag is 0; `instruction` holds its last value.
  - Decrement the gap counter; at 0, go to IDLE.
- `inputValid` = registered valid flag AND `dbg_clk_enable`, so a stalled cycle never presents an issue to the array.
- `issueCount` increments on every edge where `inputValid`=1.
- `flush`:
  - Next edge: FIFO emptied, FSM to IDLE, valid flag cleared.
  - `instruction` and `issueCount` are retained.
  - A word presented in the flush cycle is dropped.
- `rst` mid-issue: immediate return to reset values at the next edge; the partially repeated instruction is discarded.

## Timing
- Latency: a word accepted at edge k into an empty FIFO with the FSM in IDLE gives `inputValid`=1 in the cycle after edge k+1. The issue latency is 2 edges.
- A word with rep=R holds `inputValid`=1 for exactly R+1 enabled cycles.
- With GAP_CYCLES=0, consecutive FIFO words issue with no bubble.
- With GAP_CYCLES=G>0, exactly G cycles of `inputValid`=0 follow each word. A further 1-cycle IDLE pop bubble occurs before the next word, for G+1 idle cycles in total.
- `dbg_clk_enable`=0 for N cycles stretches the current state by N cycles. `inputValid` reads 0 during those cycles, and no counter moves except the FIFO push side.
- `fifoCount`/`busy` reflect state after the previous edge (registered).

## Test plan
- Reset then single push (instr=0xA5, rep=0): `inputValid`=1 for one cycle exactly 2 edges after acceptance, `instruction`=0xA5, `issueCount`=1, `busy` returns 0.
- Push 0x11 (rep=2) and 0x22 (rep=0), GAP_CYCLES=0: `inputValid` high 4 consecutive cycles, `instruction` 0x11,0x11,0x11,0x22, `issueCount`=4.
- GAP_CYCLES=2, push two rep=0 words: valid pattern 1,0,0,0,1 (2 gap cycles plus 1 IDLE pop bubble).
- Fill FIFO_DEPTH=4 words while stalled (`dbg_clk_enable`=0): `in_ready` drops after the 4th push, `fifoCount`=4, `inputValid` stays 0. Release the stall: all words issue in order.
- Mid-repeat (0x33, rep=5, after 2 issues) assert `flush` with 2 words queued: next cycle `inputValid`=0, `fifoCount`=0, `issueCount`=2, `instruction`=0x33 held.
- Assert `rst` during ISSUE: all outputs return to reset values after one edge. Counter wrap: with CNT_WIDTH=4, 17 issues leave `issueCount`=1.
